// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lends one uart_txB transmitter to NREQ byte-stream
// requesters. It grants the transmitter for a whole message and drives the
// Tx_start / Tx_EN / Tx_done handshake one byte at a time.
module uart_tx_arbiter #(
  parameter int NREQ      = 4,
  parameter int DW        = 8,
  parameter int MAX_BYTES = 64,
  parameter int GAP_CYC   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   grant,
  output logic              busy,
  output logic [DW-1:0]     tx_data,
  output logic              Tx_start,
  input  logic              Tx_EN,
  input  logic              Tx_done,
  output logic              err_overlen
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(MAX_BYTES + 1);
  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_BYTES);
  localparam logic [GW-1:0] GAP_LAST = (GAP_CYC > 0) ? GW'(GAP_CYC - 1) : '0;
  localparam logic [PW-1:0] PTR_LAST = PW'(NREQ - 1);

  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_DONE, GAP} state_t;

  state_t        state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] owner;
  logic [PW-1:0] pick;
  logic [PW-1:0] idx;
  logic          pick_found;
  logic [CW-1:0] cnt;
  logic [GW-1:0] gap_cnt;
  logic          last_q;
  logic          xfer;
  logic          msg_end;

  // Round-robin search starting at ptr, wrapping modulo NREQ.
  always_comb begin
    pick       = '0;
    idx        = '0;
    pick_found = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = PW'((32'(ptr) + i) % 32'(NREQ));
      if (!pick_found && req_valid[idx]) begin
        pick       = idx;
        pick_found = 1'b1;
      end
    end
  end

  // Handshake decodes and status outputs.
  always_comb begin
    xfer        = (state == LOAD) && Tx_EN && req_valid[owner];
    msg_end     = (state == WAIT_DONE) && Tx_done && (last_q || (cnt == CNT_MAX));
    err_overlen = (state == WAIT_DONE) && Tx_done && !last_q && (cnt == CNT_MAX);
    Tx_start    = (state == START);
    busy        = (state != IDLE);
    req_ready   = '0;
    if ((state == LOAD) && Tx_EN) begin
      req_ready = grant;
    end
  end

  // Message sequencer: arbitrate, load byte, pulse start, await done, optional gap.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      grant   <= '0;
      ptr     <= '0;
      owner   <= '0;
      cnt     <= '0;
      gap_cnt <= '0;
      tx_data <= '0;
      last_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            owner <= pick;
            grant <= {{(NREQ-1){1'b0}}, 1'b1} << pick;
            cnt   <= '0;
            state <= LOAD;
          end
        end
        LOAD: begin
          if (xfer) begin
            tx_data <= req_data[int'(owner)*DW +: DW];
            last_q  <= req_last[owner];
            cnt     <= cnt + 1'b1;
            state   <= START;
          end
        end
        START: begin
          state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (msg_end) begin
            grant   <= '0;
            ptr     <= (owner == PTR_LAST) ? '0 : owner + 1'b1;
            gap_cnt <= '0;
            state   <= (GAP_CYC > 0) ? GAP : IDLE;
          end else if (Tx_done) begin
            state <= LOAD;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (NREQ=4, DW=8, MAX_BYTES=4, GAP_CYC=5).
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic [3:0]  grant;
  logic        busy;
  logic [7:0]  tx_data;
  logic        Tx_start;
  logic        Tx_EN;
  logic        Tx_done;
  logic        err_overlen;

  int n_cmp = 0;
  int n_err = 0;
  int n_starts = 0;

  uart_tx_arbiter #(.NREQ(4), .DW(8), .MAX_BYTES(4), .GAP_CYC(5)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .grant(grant), .busy(busy),
    .tx_data(tx_data), .Tx_start(Tx_start),
    .Tx_EN(Tx_EN), .Tx_done(Tx_done), .err_overlen(err_overlen)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (Tx_start === 1'b1) n_starts++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic set_req(input int r, input logic v, input logic [7:0] d, input logic l);
    req_valid[r] = v;
    req_data[r*8 +: 8] = d;
    req_last[r] = l;
  endtask

  task automatic do_reset;
    rst = 1'b1; Tx_EN = 1'b1; Tx_done = 1'b0;
    req_valid = '0; req_data = '0; req_last = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_start(output int waited, output bit ok);
    ok = 1'b0; waited = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (Tx_start === 1'b1) begin ok = 1'b1; waited = i; break; end
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin ok = 1'b1; break; end
    end
  endtask

  // Transmitter model: called at the START cycle; returns one cycle after Tx_done.
  task automatic finish_tx(input int len, output logic e0, output logic e1);
    Tx_EN = 1'b0;
    repeat (len) @(negedge clk);
    Tx_done = 1'b1;
    #1 e0 = err_overlen;
    @(negedge clk);
    e1 = err_overlen;
    Tx_done = 1'b0;
    Tx_EN = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1; Tx_EN = 1'b1; Tx_done = 1'b0;
    req_valid = 4'hF; req_data = 32'hDEADBEEF; req_last = 4'h0;
    repeat (2) @(negedge clk);
    n_cmp++; if (grant !== 4'b0000) begin n_err++; $display("FAIL rst_grant got=%b exp=0000", grant); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got=%b exp=0", busy); end
    n_cmp++; if (Tx_start !== 1'b0) begin n_err++; $display("FAIL rst_start got=%b exp=0", Tx_start); end
    n_cmp++; if (tx_data !== 8'h00) begin n_err++; $display("FAIL rst_data got=%h exp=00", tx_data); end
    n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL rst_ready got=%b exp=0000", req_ready); end
    n_cmp++; if (err_overlen !== 1'b0) begin n_err++; $display("FAIL rst_err got=%b exp=0", err_overlen); end
    req_valid = '0; req_data = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single;
    int w; bit ok; int s0; logic e0, e1;
    s0 = n_starts;
    set_req(1, 1'b1, 8'hB1, 1'b0);
    wait_start(w, ok);
    n_cmp++; if (!ok || w != 2) begin n_err++; $display("FAIL t1_first_latency got=%0d exp=2", w); end
    n_cmp++; if (tx_data !== 8'hB1) begin n_err++; $display("FAIL t1_byte0 got=%h exp=b1", tx_data); end
    n_cmp++; if (grant !== 4'b0010) begin n_err++; $display("FAIL t1_grant got=%b exp=0010", grant); end
    set_req(1, 1'b1, 8'h55, 1'b0);
    finish_tx(3, e0, e1);
    wait_start(w, ok);
    n_cmp++; if (!ok || w != 1) begin n_err++; $display("FAIL t1_followon_latency got=%0d exp=1", w); end
    n_cmp++; if (tx_data !== 8'h55) begin n_err++; $display("FAIL t1_byte1 got=%h exp=55", tx_data); end
    set_req(1, 1'b1, 8'h0A, 1'b1);
    finish_tx(3, e0, e1);
    wait_start(w, ok);
    n_cmp++; if (!ok || tx_data !== 8'h0A) begin n_err++; $display("FAIL t1_byte2 got=%h exp=0a", tx_data); end
    n_cmp++; if (grant !== 4'b0010) begin n_err++; $display("FAIL t1_grant_held got=%b exp=0010", grant); end
    set_req(1, 1'b0, 8'h00, 1'b0);
    finish_tx(3, e0, e1);
    n_cmp++; if (grant !== 4'b0000) begin n_err++; $display("FAIL t1_release got=%b exp=0000", grant); end
    repeat (5) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL t1_idle got=%b exp=0", busy); end
    n_cmp++; if (n_starts - s0 != 3) begin n_err++; $display("FAIL t1_start_count got=%0d exp=3", n_starts - s0); end
    set_req(1, 1'b1, 8'h11, 1'b1);
    set_req(2, 1'b1, 8'h22, 1'b1);
    @(negedge clk);
    n_cmp++; if (grant !== 4'b0100) begin n_err++; $display("FAIL t1_ptr2 got=%b exp=0100", grant); end
  endtask

  task automatic test_rotation;
    int w; bit ok; logic e0, e1;
    do_reset;
    set_req(0, 1'b1, 8'hA0, 1'b1);
    set_req(2, 1'b1, 8'hC2, 1'b1);
    wait_start(w, ok);
    n_cmp++; if (!ok || grant !== 4'b0001) begin n_err++; $display("FAIL t2_first got=%b exp=0001", grant); end
    n_cmp++; if (tx_data !== 8'hA0) begin n_err++; $display("FAIL t2_data0 got=%h exp=a0", tx_data); end
    set_req(0, 1'b1, 8'hA1, 1'b1);
    finish_tx(2, e0, e1);
    wait_start(w, ok);
    n_cmp++; if (!ok || grant !== 4'b0100) begin n_err++; $display("FAIL t2_second got=%b exp=0100", grant); end
    n_cmp++; if (tx_data !== 8'hC2) begin n_err++; $display("FAIL t2_data1 got=%h exp=c2", tx_data); end
    set_req(2, 1'b0, 8'h00, 1'b0);
    finish_tx(2, e0, e1);
    wait_start(w, ok);
    n_cmp++; if (!ok || grant !== 4'b0001) begin n_err++; $display("FAIL t2_third got=%b exp=0001", grant); end
    n_cmp++; if (tx_data !== 8'hA1) begin n_err++; $display("FAIL t2_data2 got=%h exp=a1", tx_data); end
    set_req(0, 1'b0, 8'h00, 1'b0);
    finish_tx(2, e0, e1);
    wait_idle(ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL t2_idle_timeout got=busy exp=idle"); end
  endtask

  task automatic test_overlen;
    int w; bit ok; logic e0, e1; logic [7:0] exp;
    set_req(0, 1'b1, 8'h0F, 1'b1);
    set_req(1, 1'b1, 8'h10, 1'b0);
    for (int b = 0; b < 4; b++) begin
      exp = 8'h10 + 8'(b);
      wait_start(w, ok);
      n_cmp++; if (!ok || tx_data !== exp) begin n_err++; $display("FAIL t3_byte%0d got=%h exp=%h", b, tx_data, exp); end
      n_cmp++; if (grant !== 4'b0010) begin n_err++; $display("FAIL t3_grant%0d got=%b exp=0010", b, grant); end
      set_req(1, 1'b1, exp + 8'h01, 1'b0);
      finish_tx(2, e0, e1);
      if (b < 3) begin
        n_cmp++; if (e0 !== 1'b0) begin n_err++; $display("FAIL t3_early_err%0d got=%b exp=0", b, e0); end
      end else begin
        n_cmp++; if (e0 !== 1'b1) begin n_err++; $display("FAIL t3_err_pulse got=%b exp=1", e0); end
        n_cmp++; if (e1 !== 1'b0) begin n_err++; $display("FAIL t3_err_width got=%b exp=0", e1); end
        n_cmp++; if (grant !== 4'b0000) begin n_err++; $display("FAIL t3_cut got=%b exp=0000", grant); end
      end
    end
    wait_start(w, ok);
    n_cmp++; if (!ok || grant !== 4'b0001) begin n_err++; $display("FAIL t3_next_owner got=%b exp=0001", grant); end
    n_cmp++; if (tx_data !== 8'h0F) begin n_err++; $display("FAIL t3_next_data got=%h exp=0f", tx_data); end
    set_req(0, 1'b0, 8'h00, 1'b0);
    set_req(1, 1'b0, 8'h00, 1'b0);
    finish_tx(2, e0, e1);
    wait_idle(ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL t3_idle_timeout got=busy exp=idle"); end
  endtask

  task automatic test_txen_stall;
    bit bad; bit ok; logic e0, e1;
    bad = 1'b0;
    Tx_EN = 1'b0;
    set_req(2, 1'b1, 8'h5A, 1'b1);
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      if (req_ready !== 4'b0000 || Tx_start !== 1'b0 || grant !== 4'b0100 || tx_data !== 8'h0F) bad = 1'b1;
      @(negedge clk);
    end
    n_cmp++; if (bad) begin n_err++; $display("FAIL t4_stall got=ready:%b start:%b grant:%b exp=0000/0/0100", req_ready, Tx_start, grant); end
    Tx_EN = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL t4_ready got=%b exp=0100", req_ready); end
    n_cmp++; if (Tx_start !== 1'b0) begin n_err++; $display("FAIL t4_no_early_start got=%b exp=0", Tx_start); end
    @(negedge clk);
    n_cmp++; if (Tx_start !== 1'b1) begin n_err++; $display("FAIL t4_start got=%b exp=1", Tx_start); end
    n_cmp++; if (tx_data !== 8'h5A) begin n_err++; $display("FAIL t4_data got=%h exp=5a", tx_data); end
    set_req(2, 1'b0, 8'h00, 1'b0);
    finish_tx(2, e0, e1);
    wait_idle(ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL t4_idle_timeout got=busy exp=idle"); end
  endtask

  task automatic test_reset_midmsg;
    int w; bit ok; logic e0, e1;
    set_req(3, 1'b1, 8'h31, 1'b0);
    set_req(0, 1'b1, 8'hE0, 1'b1);
    wait_start(w, ok);
    n_cmp++; if (!ok || grant !== 4'b1000) begin n_err++; $display("FAIL t5_owner got=%b exp=1000", grant); end
    set_req(3, 1'b1, 8'h32, 1'b0);
    finish_tx(2, e0, e1);
    wait_start(w, ok);
    n_cmp++; if (!ok || tx_data !== 8'h32) begin n_err++; $display("FAIL t5_byte2 got=%h exp=32", tx_data); end
    Tx_EN = 1'b0;
    @(negedge clk);
    rst = 1'b1; Tx_EN = 1'b1;
    @(negedge clk);
    n_cmp++; if (grant !== 4'b0000) begin n_err++; $display("FAIL t5_grant got=%b exp=0000", grant); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL t5_busy got=%b exp=0", busy); end
    n_cmp++; if (tx_data !== 8'h00) begin n_err++; $display("FAIL t5_data got=%h exp=00", tx_data); end
    n_cmp++; if (req_ready !== 4'b0000 || Tx_start !== 1'b0 || err_overlen !== 1'b0) begin
      n_err++; $display("FAIL t5_outs got=ready:%b start:%b err:%b exp=0000/0/0", req_ready, Tx_start, err_overlen);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (grant !== 4'b0001) begin n_err++; $display("FAIL t5_rearb got=%b exp=0001", grant); end
  endtask

  task automatic test_gap;
    int w; bit ok; int gap; logic e0, e1;
    do_reset;
    set_req(1, 1'b1, 8'h71, 1'b1);
    set_req(3, 1'b1, 8'h73, 1'b1);
    wait_start(w, ok);
    n_cmp++; if (!ok || grant !== 4'b0010) begin n_err++; $display("FAIL t6_first got=%b exp=0010", grant); end
    set_req(1, 1'b0, 8'h00, 1'b0);
    Tx_EN = 1'b0;
    repeat (2) @(negedge clk);
    Tx_done = 1'b1;
    @(negedge clk);
    Tx_done = 1'b0; Tx_EN = 1'b1;
    gap = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy === 1'b1 && grant === 4'b0000) gap++;
      else break;
      Tx_done = (i == 1);
      @(negedge clk);
    end
    Tx_done = 1'b0;
    n_cmp++; if (gap != 5) begin n_err++; $display("FAIL t6_gap_len got=%0d exp=5", gap); end
    @(negedge clk);
    n_cmp++; if (grant !== 4'b1000) begin n_err++; $display("FAIL t6_second got=%b exp=1000", grant); end
    wait_start(w, ok);
    n_cmp++; if (!ok || w != 1 || tx_data !== 8'h73) begin n_err++; $display("FAIL t6_data got=%h/%0d exp=73/1", tx_data, w); end
    set_req(3, 1'b0, 8'h00, 1'b0);
    finish_tx(2, e0, e1);
    wait_idle(ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL t6_idle_timeout got=busy exp=idle"); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_rotation;
    test_overlen;
    test_txen_stall;
    test_reset_midmsg;
    test_gap;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
